mbist_march_ctrl: RTL and testbench

MBIST_MARCH_CTRL -- requirements
Module: mbist_march_ctrl

---
 rtl/mbist_march_ctrl.sv | 223 ++++++++++++++++++++++
 tb/tb_mbist_march_ctrl.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mbist_march_ctrl.sv
// March C- memory BIST controller.
// Sequences the six March C- elements over addresses 0..CAPACITY, issues one
// memory operation per cycle, and checks read data through a two-stage
// compare pipeline that matches the memory's two-cycle read latency.
module mbist_march_ctrl #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 9,
   parameter int CAPACITY   = 511
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   output logic                  write_read,
   output logic [ADDR_WIDTH-1:0] address,
   output logic [DATA_WIDTH-1:0] wdata,
   input  logic [DATA_WIDTH-1:0] rdata,
   output logic                  busy,
   output logic                  done,
   output logic                  fail,
   output logic [ADDR_WIDTH-1:0] fail_addr,
   output logic [DATA_WIDTH-1:0] fail_data,
   output logic [15:0]           err_cnt
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETUP,
      ST_RUN,
      ST_DRAIN,
      ST_DONE
   } state_t;

   localparam logic [ADDR_WIDTH-1:0] LP_CAP       = ADDR_WIDTH'(CAPACITY);
   localparam logic [2:0]            LP_LAST_ELEM = 3'd5;

   // Element index 0..5 selects E0..E5 of March C-.
   // E3 and E4 walk addresses downward.
   function automatic logic f_down(input logic [2:0] e);
      return (e == 3'd3) || (e == 3'd4);
   endfunction

   // E1..E4 are (read, write) pairs; E0 is write-only, E5 read-only.
   function automatic logic f_rw(input logic [2:0] e);
      return (e >= 3'd1) && (e <= 3'd4);
   endfunction

   // Write pattern bit per element: E1 and E3 write ones, the rest zeros.
   function automatic logic f_wbit(input logic [2:0] e);
      return (e == 3'd1) || (e == 3'd3);
   endfunction

   // Expected read pattern bit: E2 and E4 read ones, the rest zeros.
   function automatic logic f_rbit(input logic [2:0] e);
      return (e == 3'd2) || (e == 3'd4);
   endfunction

   state_t                r_state;
   logic [2:0]            r_elem;
   logic                  r_phase;
   logic                  r_drain;
   logic                  r_write_read;
   logic [ADDR_WIDTH-1:0] r_address;
   logic [DATA_WIDTH-1:0] r_wdata;
   logic                  r_busy;
   logic                  r_done;

   logic                  r_p1_vld;
   logic [ADDR_WIDTH-1:0] r_p1_addr;
   logic [DATA_WIDTH-1:0] r_p1_exp;
   logic                  r_p2_vld;
   logic [ADDR_WIDTH-1:0] r_p2_addr;
   logic [DATA_WIDTH-1:0] r_p2_exp;

   logic                  r_fail;
   logic [ADDR_WIDTH-1:0] r_fail_addr;
   logic [DATA_WIDTH-1:0] r_fail_data;
   logic [15:0]           r_err_cnt;

   logic                  w_start_go;
   logic                  w_down;
   logic [ADDR_WIDTH-1:0] w_last_addr;
   logic [ADDR_WIDTH-1:0] w_next_addr;
   logic [2:0]            w_next_elem;
   logic                  w_mis;

   assign w_start_go  = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
   assign w_down      = f_down(r_elem);
   assign w_last_addr = w_down ? '0 : LP_CAP;
   assign w_next_addr = w_down ? (r_address - ADDR_WIDTH'(1))
                               : (r_address + ADDR_WIDTH'(1));
   assign w_next_elem = r_elem + 3'd1;
   assign w_mis       = r_p2_vld && (rdata != r_p2_exp);

   // Control FSM: element sequencing, address walk and registered memory command.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= ST_IDLE;
         r_elem       <= '0;
         r_phase      <= 1'b0;
         r_drain      <= 1'b0;
         r_write_read <= 1'b0;
         r_address    <= '0;
         r_wdata      <= '0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
      end else begin
         unique case (r_state)
            ST_IDLE, ST_DONE: begin
               r_write_read <= 1'b0;
               r_address    <= '0;
               // E0 writes zeros, so the idle value of wdata is already its pattern.
               r_wdata      <= '0;
               if (start) begin
                  r_state <= ST_SETUP;
                  r_busy  <= 1'b1;
                  r_done  <= 1'b0;
                  r_elem  <= '0;
               end
            end
            ST_SETUP: begin
               r_state      <= ST_RUN;
               r_phase      <= 1'b0;
               r_address    <= w_down ? LP_CAP : '0;
               r_write_read <= (r_elem == 3'd0);
            end
            ST_RUN: begin
               if (f_rw(r_elem) && !r_phase) begin
                  // Read just issued; the write to the same address follows.
                  r_phase      <= 1'b1;
                  r_write_read <= 1'b1;
               end else begin
                  r_phase <= 1'b0;
                  if (r_address == w_last_addr) begin
                     r_write_read <= 1'b0;
                     r_address    <= '0;
                     if (r_elem == LP_LAST_ELEM) begin
                        r_state <= ST_DRAIN;
                        r_drain <= 1'b0;
                        r_wdata <= '0;
                     end else begin
                        r_state <= ST_SETUP;
                        r_elem  <= w_next_elem;
                        r_wdata <= {DATA_WIDTH{f_wbit(w_next_elem)}};
                     end
                  end else begin
                     r_address    <= w_next_addr;
                     r_write_read <= (r_elem == 3'd0);
                  end
               end
            end
            ST_DRAIN: begin
               r_write_read <= 1'b0;
               r_address    <= '0;
               r_wdata      <= '0;
               if (r_drain) begin
                  r_state <= ST_DONE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
               end else begin
                  r_drain <= 1'b1;
               end
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   // Compare pipeline: tag each read with its address and expected word, two stages deep.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_p1_vld  <= 1'b0;
         r_p1_addr <= '0;
         r_p1_exp  <= '0;
         r_p2_vld  <= 1'b0;
         r_p2_addr <= '0;
         r_p2_exp  <= '0;
      end else begin
         r_p1_vld  <= (r_state == ST_RUN) && !r_write_read;
         r_p1_addr <= r_address;
         r_p1_exp  <= {DATA_WIDTH{f_rbit(r_elem)}};
         r_p2_vld  <= r_p1_vld;
         r_p2_addr <= r_p1_addr;
         r_p2_exp  <= r_p1_exp;
      end
   end

   // Result tracking: sticky fail flag, first-failure capture, saturating error count.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_fail      <= 1'b0;
         r_fail_addr <= '0;
         r_fail_data <= '0;
         r_err_cnt   <= '0;
      end else if (w_start_go) begin
         r_fail      <= 1'b0;
         r_fail_addr <= '0;
         r_fail_data <= '0;
         r_err_cnt   <= '0;
      end else if (w_mis) begin
         r_fail <= 1'b1;
         if (!r_fail) begin
            r_fail_addr <= r_p2_addr;
            r_fail_data <= rdata;
         end
         if (r_err_cnt != '1) begin
            r_err_cnt <= r_err_cnt + 16'd1;
         end
      end
   end

   assign write_read = r_write_read;
   assign address    = r_address;
   assign wdata      = r_wdata;
   assign busy       = r_busy;
   assign done       = r_done;
   assign fail       = r_fail;
   assign fail_addr  = r_fail_addr;
   assign fail_data  = r_fail_data;
   assign err_cnt    = r_err_cnt;

endmodule

// File: tb/tb_mbist_march_ctrl.sv
// Self-checking bench for mbist_march_ctrl: a faultable memory model drives
// rdata, and a March C- reference computed directly from the algorithm gives
// the expected command trace, cycle count and error results.
module tb_mbist_march_ctrl;

   localparam int DW    = 8;
   localparam int AW    = 3;
   localparam int CAP   = 7;
   localparam int N     = CAP + 1;
   localparam int TOTAL = 10 * N + 8;

   logic          clk;
   logic          rst;
   logic          start;
   logic          write_read;
   logic [AW-1:0] address;
   logic [DW-1:0] wdata;
   logic [DW-1:0] rdata;
   logic          busy;
   logic          done;
   logic          fail;
   logic [AW-1:0] fail_addr;
   logic [DW-1:0] fail_data;
   logic [15:0]   err_cnt;

   int n_assert = 0;
   int n_fail   = 0;

   // Fault configuration of the memory model.
   bit            dead_en;
   logic [AW-1:0] dead_a;
   logic [DW-1:0] dead_v;
   logic [DW-1:0] sa0;
   logic [DW-1:0] sa1;

   // March C- as a table: direction, read/write presence and patterns per element.
   localparam bit            DOWN  [6] = '{0, 0, 0, 1, 1, 0};
   localparam bit            HAS_R [6] = '{0, 1, 1, 1, 1, 1};
   localparam bit            HAS_W [6] = '{1, 1, 1, 1, 1, 0};
   localparam logic [DW-1:0] WPAT  [6] = '{'0, '1, '0, '1, '0, '0};
   localparam logic [DW-1:0] RPAT  [6] = '{'0, '0, '1, '0, '1, '0};

   typedef struct packed {
      logic          wr;
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      logic          ca;
      logic          cd;
   } op_t;

   op_t exp_q[$];

   mbist_march_ctrl #(
      .DATA_WIDTH(DW),
      .ADDR_WIDTH(AW),
      .CAPACITY  (CAP)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .write_read(write_read),
      .address   (address),
      .wdata     (wdata),
      .rdata     (rdata),
      .busy      (busy),
      .done      (done),
      .fail      (fail),
      .fail_addr (fail_addr),
      .fail_data (fail_data),
      .err_cnt   (err_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [DW-1:0] fault_read(input logic [DW-1:0] stored, input int a);
      logic [DW-1:0] v;
      v = (dead_en && a == int'(dead_a)) ? dead_v : stored;
      return (v & ~sa0) | sa1;
   endfunction

   // Memory: write at the end of a write cycle, read data two cycles after the read cycle.
   logic [DW-1:0] mem [N];
   logic [DW-1:0] rd1;
   logic [DW-1:0] rd2;
   always @(posedge clk) begin
      rd1 <= fault_read(mem[address], int'(address));
      rd2 <= rd1;
      if (write_read && !(dead_en && address == dead_a)) mem[address] <= wdata;
   end
   assign rdata = rd2;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_outputs_zero(input string tag);
      chk({tag, " write_read"}, 32'(write_read), 32'(0));
      chk({tag, " address"},    32'(address),    32'(0));
      chk({tag, " wdata"},      32'(wdata),      32'(0));
      chk({tag, " busy"},       32'(busy),       32'(0));
      chk({tag, " done"},       32'(done),       32'(0));
      chk({tag, " fail"},       32'(fail),       32'(0));
      chk({tag, " fail_addr"},  32'(fail_addr),  32'(0));
      chk({tag, " fail_data"},  32'(fail_data),  32'(0));
      chk({tag, " err_cnt"},    32'(err_cnt),    32'(0));
   endtask

   // Expected per-cycle command stream from SETUP entry through DRAIN.
   task automatic build_expect();
      int a;
      exp_q.delete();
      for (int e = 0; e < 6; e++) begin
         exp_q.push_back('{wr: 1'b0, a: '0, d: WPAT[e], ca: 1'b0, cd: 1'b1});
         for (int k = 0; k < N; k++) begin
            a = DOWN[e] ? (CAP - k) : k;
            if (HAS_R[e]) exp_q.push_back('{wr: 1'b0, a: AW'(a), d: WPAT[e], ca: 1'b1, cd: 1'b1});
            if (HAS_W[e]) exp_q.push_back('{wr: 1'b1, a: AW'(a), d: WPAT[e], ca: 1'b1, cd: 1'b1});
         end
      end
      for (int k = 0; k < 2; k++) exp_q.push_back('{wr: 1'b0, a: '0, d: '0, ca: 1'b0, cd: 1'b0});
   endtask

   // Algorithmic reference: walk March C- over an array with the same faults.
   task automatic ref_model(output int e_cnt, output int f_a, output int f_d);
      logic [DW-1:0] m [N];
      logic [DW-1:0] v;
      int a;
      e_cnt = 0;
      f_a   = 0;
      f_d   = 0;
      foreach (m[i]) m[i] = '0;
      for (int e = 0; e < 6; e++) begin
         for (int k = 0; k < N; k++) begin
            a = DOWN[e] ? (CAP - k) : k;
            if (HAS_R[e]) begin
               v = fault_read(m[a], a);
               if (v !== RPAT[e]) begin
                  if (e_cnt == 0) begin
                     f_a = a;
                     f_d = int'(v);
                  end
                  e_cnt++;
               end
            end
            if (HAS_W[e] && !(dead_en && a == int'(dead_a))) m[a] = WPAT[e];
         end
      end
      if (e_cnt > 65535) e_cnt = 65535;
   endtask

   // One complete test: pulse start, check every cycle, then check results.
   task automatic run_test(input string tag, input int restart_at);
      int            idx;
      int            e_cnt;
      int            f_a;
      int            f_d;
      op_t           op;
      logic [AW-1:0] a_o;
      logic [AW-1:0] a_x;
      logic [DW-1:0] d_o;
      logic [DW-1:0] d_x;
      build_expect();
      ref_model(e_cnt, f_a, f_d);
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      idx = 0;
      while (done !== 1'b1 && idx < 4 * TOTAL) begin
         if (idx < exp_q.size()) begin
            op  = exp_q[idx];
            a_o = op.ca ? address : '0;
            a_x = op.ca ? op.a    : '0;
            d_o = op.cd ? wdata   : '0;
            d_x = op.cd ? op.d    : '0;
            chk($sformatf("%s trace[%0d] {wr,addr,wdata}", tag, idx),
                32'({write_read, a_o, d_o}), 32'({op.wr, a_x, d_x}));
         end
         chk($sformatf("%s busy[%0d]", tag, idx), 32'(busy), 32'(1));
         start = (idx == restart_at);
         @(negedge clk);
         idx++;
      end
      start = 1'b0;
      chk({tag, " cycles to done"}, 32'(idx),       32'(TOTAL));
      chk({tag, " done"},           32'(done),      32'(1));
      chk({tag, " busy at done"},   32'(busy),      32'(0));
      chk({tag, " fail"},           32'(fail),      32'(e_cnt != 0));
      chk({tag, " err_cnt"},        32'(err_cnt),   32'(e_cnt));
      chk({tag, " fail_addr"},      32'(fail_addr), 32'(f_a));
      chk({tag, " fail_data"},      32'(fail_data), 32'(f_d));
      chk({tag, " idle write_read"}, 32'(write_read), 32'(0));
      chk({tag, " idle address"},   32'(address),   32'(0));
      chk({tag, " idle wdata"},     32'(wdata),     32'(0));
      repeat (3) @(negedge clk);
      chk({tag, " done held"},      32'(done),      32'(1));
   endtask

   initial begin
      rst     = 1'b1;
      start   = 1'b0;
      dead_en = 1'b0;
      dead_a  = '0;
      dead_v  = '0;
      sa0     = '0;
      sa1     = '0;

      // Reset state and the first cycle after release.
      repeat (2) @(negedge clk);
      chk_outputs_zero("reset");
      rst = 1'b0;
      @(negedge clk);
      chk("post-reset write_read", 32'(write_read), 32'(0));
      chk("post-reset busy",       32'(busy),       32'(0));

      // Fault-free memory.
      run_test("clean", -1);
      chk("clean err_cnt const", 32'(err_cnt), 32'(0));

      // Address 5 ignores writes and reads 8'hA5.
      dead_en = 1'b1;
      dead_a  = AW'(5);
      dead_v  = 8'hA5;
      run_test("dead5", -1);
      chk("dead5 fail_addr const", 32'(fail_addr), 32'(5));
      chk("dead5 fail_data const", 32'(fail_data), 32'(8'hA5));
      chk("dead5 err_cnt const",   32'(err_cnt),   32'(5));
      dead_en = 1'b0;

      // Bit 0 stuck at 0 in every word.
      sa0 = 8'h01;
      run_test("sa0b0", -1);
      chk("sa0b0 fail_addr const", 32'(fail_addr), 32'(0));
      chk("sa0b0 fail_data const", 32'(fail_data), 32'(8'hFE));
      chk("sa0b0 err_cnt const",   32'(err_cnt),   32'(16));

      // Start pulsed again while busy: must not restart.
      sa0 = '0;
      run_test("restart40", 40);
      run_test("restart9", 9);

      // Reset in the middle of E2 with a fault present.
      sa0 = 8'h01;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (33) @(negedge clk);
      chk("midrst busy before",       32'(busy),          32'(1));
      chk("midrst errors before",     32'(err_cnt != 0),  32'(1));
      rst = 1'b1;
      #1;
      chk_outputs_zero("midrst");
      @(negedge clk);
      rst = 1'b0;
      sa0 = '0;
      @(negedge clk);
      chk("midrst release write_read", 32'(write_read), 32'(0));
      chk("midrst release busy",       32'(busy),       32'(0));
      repeat (4) @(negedge clk);
      chk("midrst no stale err_cnt",   32'(err_cnt),    32'(0));
      chk("midrst no stale fail",      32'(fail),       32'(0));
      run_test("after_rst", -1);

      // Randomised fault mixes.
      for (int r = 0; r < 4; r++) begin
         dead_en = 1'($urandom_range(0, 1));
         dead_a  = AW'($urandom_range(0, CAP));
         dead_v  = DW'($urandom);
         sa0     = ($urandom_range(0, 2) == 0) ? DW'(1 << $urandom_range(0, DW - 1)) : '0;
         sa1     = ($urandom_range(0, 2) == 0) ? DW'(1 << $urandom_range(0, DW - 1)) : '0;
         run_test($sformatf("rand%0d", r),
                  ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, TOTAL - 1)) : -1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
